// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types and register-file geometry.
package wb_arbiter_pkg;
  localparam int REGFILE_ADDR   = 3;
  localparam int DATAPATH_WIDTH = 64;
  localparam int NREGS          = 2 ** REGFILE_ADDR;

  typedef struct packed {
    logic                      live;
    logic [REGFILE_ADDR-1:0]   waddr;
    logic [DATAPATH_WIDTH-1:0] wdata;
  } wb_entry;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REGFILE_ADDR-1:0] addr);
    logic [NREGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Result sources in, register-file write port and pending state out.
interface wb_arbiter_if #(parameter int FIFO_DEPTH = 4);
  import wb_arbiter_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      alu_valid;
  logic [REGFILE_ADDR-1:0]   alu_waddr;
  logic [DATAPATH_WIDTH-1:0] alu_wdata;
  logic                      mem_valid;
  logic [REGFILE_ADDR-1:0]   mem_waddr;
  logic [DATAPATH_WIDTH-1:0] mem_wdata;
  logic                      mem_ready;
  logic                      wena;
  logic [REGFILE_ADDR-1:0]   waddr;
  logic [DATAPATH_WIDTH-1:0] wdata;
  logic [NREGS-1:0]          pend_mask;
  logic [CW-1:0]             fifo_count;

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, mem_valid, mem_waddr, mem_wdata,
    output mem_ready, wena, waddr, wdata, pend_mask, fifo_count
  );

  modport master (
    output alu_valid, alu_waddr, alu_wdata, mem_valid, mem_waddr, mem_wdata,
    input  mem_ready, wena, waddr, wdata, pend_mask, fifo_count
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// Load-return circular buffer with parallel squash of live bits by address.
// Latency: push visible at head the cycle after; pop retires head at the edge.
// Backpressure: caller must not push when full; count exposes occupancy.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wb_entry                 push_entry,
  input  logic                    pop,
  input  logic                    squash_valid,
  input  logic [REGFILE_ADDR-1:0] squash_addr,
  output wb_entry                 head,
  output logic [CW-1:0]           count,
  output logic [NREGS-1:0]        pend_mask
);
  wb_entry       mem [FIFO_DEPTH];
  logic [PW-1:0] rptr, wptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (squash_valid && mem[i].waddr == squash_addr) mem[i].live <= 1'b0;
      end
      // Retired slots drop their live bit so pend_mask only sees occupied entries.
      if (pop) begin
        mem[rptr].live <= 1'b0;
        rptr           <= rptr + PW'(1);
      end
      if (push) begin
        mem[wptr]      <= push_entry;
        mem[wptr].live <= push_entry.live & ~(squash_valid && push_entry.waddr == squash_addr);
        wptr           <= wptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (mem[i].live) pend_mask = pend_mask | reg_onehot(mem[i].waddr);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU first, then queued loads, then bypassed loads.
// Latency: one cycle from acceptance to registered wena/waddr/wdata.
// Backpressure: mem_ready low while the load buffer is full or in reset.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  wb_entry                   head;
  logic [CW-1:0]             count;
  logic                      fifo_empty;
  logic                      sel_fifo;
  logic                      bypass;
  logic                      push;
  logic                      wena_nxt;
  logic [REGFILE_ADDR-1:0]   waddr_nxt;
  logic [DATAPATH_WIDTH-1:0] wdata_nxt;

  assign fifo_empty    = (count == '0);
  assign bus.mem_ready = ~reset && (count < CW'(FIFO_DEPTH));
  assign sel_fifo      = ~bus.alu_valid && ~fifo_empty;
  assign bypass        = ~bus.alu_valid && fifo_empty && bus.mem_valid;
  assign push          = bus.mem_valid && bus.mem_ready && ~bypass;
  assign bus.fifo_count = count;

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_entry   ({1'b1, bus.mem_waddr, bus.mem_wdata}),
    .pop          (sel_fifo),
    .squash_valid (bus.alu_valid),
    .squash_addr  (bus.alu_waddr),
    .head         (head),
    .count        (count),
    .pend_mask    (bus.pend_mask)
  );

  always_comb begin
    wena_nxt  = 1'b0;
    waddr_nxt = '0;
    wdata_nxt = '0;
    if (bus.alu_valid) begin
      wena_nxt  = 1'b1;
      waddr_nxt = bus.alu_waddr;
      wdata_nxt = bus.alu_wdata;
    end else if (sel_fifo) begin
      // A squashed head still pops, but writes nothing.
      wena_nxt  = head.live;
      waddr_nxt = head.waddr;
      wdata_nxt = head.wdata;
    end else if (bypass) begin
      wena_nxt  = 1'b1;
      waddr_nxt = bus.mem_waddr;
      wdata_nxt = bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wena  <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
    end else begin
      bus.wena  <= wena_nxt;
      bus.waddr <= waddr_nxt;
      bus.wdata <= wdata_nxt;
    end
  end
endmodule
